gpr_wb_arb: RTL and testbench
=============================

# gpr_wb_arb

Write-back arbiter and pending-write scoreboard for the general register file. Merges register results from the single-cycle ALU path and the multi-cycle memory/load path into the register file's one write port. Buffers load results in a small FIFO and tracks which registers still owe a result so decode can stall on hazards. Sits between the execute/memory stages and the register file write port.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (32 registers)
- FIFO_DEPTH, 2, load-result FIFO entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive cycles the ALU may block a non-empty FIFO before it is throttled (≥1)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle
- alu_ready  out  1  arbiter accepts ALU result; the source holds addr/data while low
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load result present
- mem_ready  out  1  FIFO can accept (not full)
- mem_addr  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- pend_set  in  1  decode issues an instruction that will write pend_addr
- pend_addr  in  ADDR_W  register to mark pending
- pending  out  2**ADDR_W  bit i = 1: register i has an outstanding write
- gpr_we_  out  1  register file write enable, active-low
- gpr_wr_addr  out  ADDR_W  register file write address
- gpr_wr_data  out  DATA_W  register file write data

## Operation
- ALU accept = alu_valid & alu_ready. Mem push = mem_valid & mem_ready.
- Selection each cycle, in priority order:
  - ALU accept → output register loads {0, alu_addr, alu_data}.
  - Else FIFO non-empty → pop head → output register loads {0, head addr, head data}.
  - Else → gpr_we_ loads 1; addr/data hold their previous values.
- Outputs gpr_we_/gpr_wr_addr/gpr_wr_data are registered. Exactly one write per cycle at most.
- mem_ready = !full. Computed from the current occupancy only: a pop in the same cycle does not free the slot for a push in that cycle.
- Push and pop in the same cycle on a non-full, non-empty FIFO: occupancy unchanged, order preserved.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is log2(FIFO_DEPTH)+1.
- Starvation counter starve_cnt:
  - Increments when the FIFO is non-empty and the ALU wins.
  - Clears when a pop occurs or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- alu_ready = !(starve_cnt == STARVE_MAX && FIFO non-empty). A throttle cycle therefore always pops the FIFO and clears the counter.
- Scoreboard:
  - pend_set sets pending[pend_addr].
  - A selection (ALU or pop) clears pending[selected addr] at the same edge at which gpr_we_ goes low.
  - Set and clear of the same register at the same edge: set wins. A newer writer is outstanding.
  - Clearing a bit that is already 0 is harmless.
- No register is special-cased; all 2**ADDR_W addresses are writable.

## Timing
- Reset (async, while reset=0):
  - gpr_we_=1, gpr_wr_addr=0, gpr_wr_data=0, pending=0.
  - FIFO empty, starve_cnt=0.
  - Hence mem_ready=1 and alu_ready=1 during and immediately after reset.
- Reset mid-operation discards FIFO contents and pending bits with no write issued. gpr_we_ deasserts asynchronously.
- ALU latency: accept at edge N → gpr_we_=0 with that data during cycle N..N+1.
- Load latency: push at edge N → earliest pop at edge N+1 → write visible during cycle N+1..N+2. There is no FIFO bypass.
- Throughput: one write per cycle sustained. With FIFO full and continuous ALU traffic, the FIFO drains at least one entry every STARVE_MAX+1 cycles.
- alu_ready and mem_ready are combinational from state only, never from the valid inputs.

## Test plan
- Reset/idle:
  - Stimulus: assert reset=0 mid-stream with FIFO holding 2 entries and pending=0x0000_0006.
  - Required: gpr_we_=1 immediately, pending=0, mem_ready=1. After release, no writes occur.
- ALU single:
  - Stimulus: pend_set r3, then alu_valid with r3/0xDEADBEEF.
  - Required: next cycle gpr_we_=0, addr=3, data=0xDEADBEEF, pending[3]=0. The following cycle gpr_we_=1.
- Load path:
  - Stimulus: mem push r7/0x12345678 with no ALU traffic.
  - Required: write of r7 appears two cycles after the push edge. mem_ready stays 1.
- Collision/FIFO full:
  - Stimulus: ALU valid every cycle (r1..). Mem pushes r10=0xA, r11=0xB, r12=0xC back-to-back.
  - Required: mem_ready=0 after 2 pushes, and r12 is held by the source. With STARVE_MAX=4, alu_ready=0 on the 5th ALU-blocked cycle and r10 is written then. FIFO order is r10, r11, r12, with no data lost.
- Scoreboard race:
  - Stimulus: pend_set r5 in the same cycle an ALU write to r5 is accepted.
  - Required: pending[5] remains 1 after the edge. It clears on the next r5 write.
- Wrap:
  - Stimulus: 10 consecutive mem pushes r0..r9 with no ALU traffic.
  - Required: writes appear in order r0..r9 with correct data, exercising pointer wrap.

Source files
------------

// File: rtl/gpr_wb_arb_if.sv
// Write-back arbiter bus: ALU result port, load result port, decode
// pending-set port, scoreboard vector and the register file write port.
interface gpr_wb_arb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                   alu_valid;
    logic                   alu_ready;
    logic [ADDR_W-1:0]      alu_addr;
    logic [DATA_W-1:0]      alu_data;

    logic                   mem_valid;
    logic                   mem_ready;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_data;

    logic                   pend_set;
    logic [ADDR_W-1:0]      pend_addr;
    logic [2**ADDR_W-1:0]   pending;

    logic                   gpr_we_;
    logic [ADDR_W-1:0]      gpr_wr_addr;
    logic [DATA_W-1:0]      gpr_wr_data;

    // Arbiter side
    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  pend_set, pend_addr,
        output alu_ready, mem_ready, pending,
        output gpr_we_, gpr_wr_addr, gpr_wr_data
    );

    // Execute/memory/decode side
    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output pend_set, pend_addr,
        input  alu_ready, mem_ready, pending,
        input  gpr_we_, gpr_wr_addr, gpr_wr_data
    );
endinterface

// File: rtl/gpr_wb_arb.sv
// Write-back arbiter: ALU results win the single register file write port,
// load results queue in a small FIFO, a starvation counter forces a FIFO pop
// after STARVE_MAX consecutive ALU wins, and a scoreboard tracks registers
// that still owe a write.
module gpr_wb_arb #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         reset,
    gpr_wb_arb_if.slave  wb
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

    logic [ADDR_W-1:0]    fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0]    fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [STV_W-1:0]     starve_q, starve_d;
    logic                 we_n_q, we_n_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [2**ADDR_W-1:0] pending_q, pending_d;

    logic                 fifo_empty, fifo_full;
    logic                 alu_acc, push, pop;
    logic                 sel_valid;
    logic [ADDR_W-1:0]    sel_addr;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);

    // Ready signals depend on registered state only, never on the valids.
    assign wb.alu_ready = !((starve_q == STV_MAX) && !fifo_empty);
    assign wb.mem_ready = !fifo_full;

    assign alu_acc = wb.alu_valid && wb.alu_ready;
    assign push    = wb.mem_valid && wb.mem_ready;
    assign pop     = !alu_acc && !fifo_empty;

    assign wb.gpr_we_     = we_n_q;
    assign wb.gpr_wr_addr = addr_q;
    assign wb.gpr_wr_data = data_q;
    assign wb.pending     = pending_q;

    // Next-state: write-port selection, FIFO bookkeeping, starvation, scoreboard.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        starve_d  = starve_q;
        we_n_d    = 1'b1;
        addr_d    = addr_q;
        data_d    = data_q;
        pending_d = pending_q;
        sel_valid = 1'b0;
        sel_addr  = wb.alu_addr;

        if (alu_acc) begin
            we_n_d    = 1'b0;
            addr_d    = wb.alu_addr;
            data_d    = wb.alu_data;
            sel_valid = 1'b1;
            sel_addr  = wb.alu_addr;
        end else if (pop) begin
            we_n_d    = 1'b0;
            addr_d    = fifo_addr_q[rd_ptr_q];
            data_d    = fifo_data_q[rd_ptr_q];
            sel_valid = 1'b1;
            sel_addr  = fifo_addr_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        // A pop does not free a slot for a same-cycle push; mem_ready already
        // reflects that, so push+pop simply leaves occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (alu_acc && (starve_q != STV_MAX)) begin
            starve_d = starve_q + STV_W'(1);
        end

        // Set after clear so a newer writer stays outstanding.
        if (sel_valid) begin
            pending_d[sel_addr] = 1'b0;
        end
        if (wb.pend_set) begin
            pending_d[wb.pend_addr] = 1'b1;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            we_n_q    <= 1'b1;
            addr_q    <= '0;
            data_q    <= '0;
            pending_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            we_n_q    <= we_n_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            pending_q <= pending_d;
        end
    end

    // FIFO storage; validity is tracked by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wb.mem_addr;
            fifo_data_q[wr_ptr_q] <= wb.mem_data;
        end
    end
endmodule

// File: tb/tb_gpr_wb_arb.sv
module tb_gpr_wb_arb;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic clk;
    logic reset;

    gpr_wb_arb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    gpr_wb_arb #(
        .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of pending loads plus plain counters.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    int            m_starve;
    bit            m_we_n;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [31:0]   m_pend;

    typedef struct {
        bit            av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        bit            mv;
        logic [AW-1:0] ma;
        logic [DW-1:0] md;
        bit            ps;
        logic [AW-1:0] pa;
        bit            e_ardy;
        bit            e_mrdy;
        bit            e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic [31:0]   e_pend;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        m_we_n   = 1'b1;
        m_addr   = '0;
        m_data   = '0;
        m_pend   = '0;
    endtask

    task automatic drive(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input bit mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                         input bit ps, input logic [AW-1:0] pa);
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_addr  = ma;
        bus.mem_data  = md;
        bus.pend_set  = ps;
        bus.pend_addr = pa;
    endtask

    task automatic idle();
        drive(0, '0, '0, 0, '0, '0, 0, '0);
    endtask

    // Called at a negedge with inputs already driven; checks readies before
    // the edge, advances the model, checks registered outputs after it.
    task automatic cycle(output bit a_acc, output bit m_acc);
        bit   ardy, mrdy, selv;
        ent_t e;
        #1;
        ardy = !((m_starve == SMAX) && (mq.size() != 0));
        mrdy = (mq.size() < DEPTH);
        check("alu_ready", 32'(bus.alu_ready), 32'(ardy));
        check("mem_ready", 32'(bus.mem_ready), 32'(mrdy));
        a_acc = bus.alu_valid && ardy;
        m_acc = bus.mem_valid && mrdy;
        selv  = 1'b0;
        if (a_acc) begin
            if (mq.size() != 0) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
            else                m_starve = 0;
            m_we_n = 1'b0;
            m_addr = bus.alu_addr;
            m_data = bus.alu_data;
            selv   = 1'b1;
        end else if (mq.size() != 0) begin
            e        = mq.pop_front();
            m_we_n   = 1'b0;
            m_addr   = e.a;
            m_data   = e.d;
            m_starve = 0;
            selv     = 1'b1;
        end else begin
            m_we_n   = 1'b1;
            m_starve = 0;
        end
        if (m_acc) begin
            e.a = bus.mem_addr;
            e.d = bus.mem_data;
            mq.push_back(e);
        end
        if (selv)         m_pend[m_addr] = 1'b0;
        if (bus.pend_set) m_pend[bus.pend_addr] = 1'b1;
        @(posedge clk);
        #1;
        check("gpr_we_",     32'(bus.gpr_we_), 32'(m_we_n));
        check("gpr_wr_addr", 32'(bus.gpr_wr_addr), 32'(m_addr));
        check("gpr_wr_data", bus.gpr_wr_data, m_data);
        check("pending",     bus.pending, m_pend);
        @(negedge clk);
    endtask

    initial begin
        bit            aa_acc, mm_acc;
        bit            hold_a, hold_m;
        ent_t          obs[$];
        ent_t          e;
        logic [AW-1:0] ra, rm;
        logic [DW-1:0] rda, rdm;
        bit            rav, rmv;

        //           av aa      ad            mv ma       md            ps pa     ardy mrdy we addr    data          pend
        tbl[0]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd3, 1, 1, 1, 5'd0,  32'h0,        32'h8};
        tbl[1]  = '{1, 5'd3,  32'hDEADBEEF, 0, 5'd0,  32'h0,        0, 5'd0, 1, 1, 0, 5'd3,  32'hDEADBEEF, 32'h0};
        tbl[2]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 1, 1, 1, 5'd3,  32'hDEADBEEF, 32'h0};
        tbl[3]  = '{0, 5'd0,  32'h0,        1, 5'd7,  32'h12345678, 0, 5'd0, 1, 1, 1, 5'd3,  32'hDEADBEEF, 32'h0};
        tbl[4]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 1, 1, 0, 5'd7,  32'h12345678, 32'h0};
        tbl[5]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 1, 1, 1, 5'd7,  32'h12345678, 32'h0};
        tbl[6]  = '{1, 5'd1,  32'h101,      1, 5'd10, 32'hA,        0, 5'd0, 1, 1, 0, 5'd1,  32'h101,      32'h0};
        tbl[7]  = '{1, 5'd2,  32'h102,      1, 5'd11, 32'hB,        0, 5'd0, 1, 1, 0, 5'd2,  32'h102,      32'h0};
        tbl[8]  = '{1, 5'd3,  32'h103,      1, 5'd12, 32'hC,        0, 5'd0, 1, 0, 0, 5'd3,  32'h103,      32'h0};
        tbl[9]  = '{1, 5'd4,  32'h104,      1, 5'd12, 32'hC,        0, 5'd0, 1, 0, 0, 5'd4,  32'h104,      32'h0};
        tbl[10] = '{1, 5'd5,  32'h105,      1, 5'd12, 32'hC,        0, 5'd0, 1, 0, 0, 5'd5,  32'h105,      32'h0};
        tbl[11] = '{1, 5'd6,  32'h106,      1, 5'd12, 32'hC,        0, 5'd0, 0, 0, 0, 5'd10, 32'hA,        32'h0};
        tbl[12] = '{1, 5'd6,  32'h106,      1, 5'd12, 32'hC,        0, 5'd0, 1, 1, 0, 5'd6,  32'h106,      32'h0};
        tbl[13] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 1, 0, 0, 5'd11, 32'hB,        32'h0};
        tbl[14] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 1, 1, 0, 5'd12, 32'hC,        32'h0};
        tbl[15] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 1, 1, 1, 5'd12, 32'hC,        32'h0};

        // Power-on reset
        reset = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_we_",     32'(bus.gpr_we_), 32'h1);
        check("rst_addr",    32'(bus.gpr_wr_addr), 32'h0);
        check("rst_data",    bus.gpr_wr_data, 32'h0);
        check("rst_pending", bus.pending, 32'h0);
        check("rst_alu_rdy", 32'(bus.alu_ready), 32'h1);
        check("rst_mem_rdy", 32'(bus.mem_ready), 32'h1);
        reset = 1'b1;

        // Directed vector table: ALU single, load path, collision / throttle
        foreach (tbl[i]) begin
            drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].mv, tbl[i].ma, tbl[i].md,
                  tbl[i].ps, tbl[i].pa);
            #1;
            check($sformatf("vec%0d_alu_rdy", i), 32'(bus.alu_ready), 32'(tbl[i].e_ardy));
            check($sformatf("vec%0d_mem_rdy", i), 32'(bus.mem_ready), 32'(tbl[i].e_mrdy));
            cycle(aa_acc, mm_acc);
            check($sformatf("vec%0d_we_", i),  32'(bus.gpr_we_), 32'(tbl[i].e_we));
            check($sformatf("vec%0d_addr", i), 32'(bus.gpr_wr_addr), 32'(tbl[i].e_addr));
            check($sformatf("vec%0d_data", i), bus.gpr_wr_data, tbl[i].e_data);
            check($sformatf("vec%0d_pend", i), bus.pending, tbl[i].e_pend);
        end

        // Scoreboard race: set and clear of r5 at the same edge
        drive(0, '0, '0, 0, '0, '0, 1, 5'd5);
        cycle(aa_acc, mm_acc);
        check("race_pend_set", 32'(bus.pending[5]), 32'h1);
        drive(1, 5'd5, 32'h55, 0, '0, '0, 1, 5'd5);
        cycle(aa_acc, mm_acc);
        check("race_set_wins", 32'(bus.pending[5]), 32'h1);
        check("race_write",    32'(bus.gpr_wr_addr), 32'd5);
        drive(1, 5'd5, 32'h56, 0, '0, '0, 0, '0);
        cycle(aa_acc, mm_acc);
        check("race_cleared",  32'(bus.pending[5]), 32'h0);
        idle();
        cycle(aa_acc, mm_acc);

        // Wrap: ten back-to-back loads with no ALU traffic
        for (int i = 0; i < 12; i++) begin
            if (i < 10) drive(0, '0, '0, 1, AW'(i), 32'h9000_0000 + i, 0, '0);
            else        idle();
            cycle(aa_acc, mm_acc);
            if (i < 10) check($sformatf("wrap_push%0d", i), 32'(mm_acc), 32'h1);
            if (bus.gpr_we_ == 1'b0) begin
                e.a = bus.gpr_wr_addr;
                e.d = bus.gpr_wr_data;
                obs.push_back(e);
            end
        end
        check("wrap_count", 32'(obs.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < obs.size()) begin
                check($sformatf("wrap_addr%0d", i), 32'(obs[i].a), 32'(i));
                check($sformatf("wrap_data%0d", i), obs[i].d, 32'h9000_0000 + i);
            end
        end

        // Mid-stream reset with two queued loads and pending = 0x6
        drive(1, 5'd20, 32'h20, 1, 5'd8, 32'h88, 1, 5'd1);
        cycle(aa_acc, mm_acc);
        drive(1, 5'd21, 32'h21, 1, 5'd9, 32'h99, 1, 5'd2);
        cycle(aa_acc, mm_acc);
        drive(1, 5'd22, 32'h22, 0, '0, '0, 0, '0);
        #1;
        check("pre_rst_full",    32'(bus.mem_ready), 32'h0);
        check("pre_rst_pending", bus.pending, 32'h6);
        reset = 1'b0;
        #1;
        check("mid_rst_we_",     32'(bus.gpr_we_), 32'h1);
        check("mid_rst_pending", bus.pending, 32'h0);
        check("mid_rst_mem_rdy", 32'(bus.mem_ready), 32'h1);
        check("mid_rst_alu_rdy", 32'(bus.alu_ready), 32'h1);
        model_reset();
        idle();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(aa_acc, mm_acc);
            check($sformatf("post_rst_nowrite%0d", i), 32'(bus.gpr_we_), 32'h1);
        end

        // Randomized traffic against the model; sources hold while not ready
        hold_a = 0;
        hold_m = 0;
        rav = 0; ra = '0; rda = '0;
        rmv = 0; rm = '0; rdm = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!hold_a) begin
                rav = ($urandom_range(0, 99) < 55);
                ra  = AW'($urandom);
                rda = $urandom;
            end
            if (!hold_m) begin
                rmv = ($urandom_range(0, 99) < 45);
                rm  = AW'($urandom);
                rdm = $urandom;
            end
            drive(rav, ra, rda, rmv, rm, rdm, ($urandom_range(0, 99) < 30), AW'($urandom));
            cycle(aa_acc, mm_acc);
            hold_a = rav && !aa_acc;
            hold_m = rmv && !mm_acc;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
